// File: rtl/traffic_pkg.sv
// Shared types and default timing constants for the
// highway/farm-road light controller and its timer companion.
package traffic_pkg;

  localparam int SHORT_DEF = 5;
  localparam int LONG_DEF  = 20;
  localparam int DEB_DEF   = 3;

  typedef enum logic {
    IDLE,
    ARMED
  } emerg_state_t;

  typedef enum logic [1:0] {
    HG_FR,
    HY_FR,
    HR_FG,
    HR_FY
  } lamp_state_t;

endpackage

// File: rtl/traffic_timer_if.sv
// Link between the light-sequencing FSM (master)
// and the timer/conditioning block (slave).
interface traffic_timer_if;
  logic ST;
  logic HY;
  logic TS;
  logic TL;
  logic C;
  logic Emergency;

  modport master (
    output ST, HY,
    input  TS, TL, C, Emergency
  );

  modport slave (
    input  ST, HY,
    output TS, TL, C, Emergency
  );
endinterface

// File: rtl/traffic_timer_car_debounce.sv
// Farm-road car sensor: two-flop synchroniser followed by a
// stability counter that only moves C after DEB_CYCLES agreeing cycles.
module car_debounce #(
  parameter int DEB_CYCLES = 3
) (
  input  logic Clk,
  input  logic reset,
  input  logic car_raw,
  output logic C
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DEB_CYCLES - 1);

  logic s1;
  logic s2;
  logic [DW-1:0] dcnt;

  always_ff @(posedge Clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      C    <= 1'b0;
      dcnt <= '0;
    end else begin
      s1 <= car_raw;
      s2 <= s1;
      if (s2 == C) begin
        dcnt <= '0;
      end else if (dcnt == DLAST) begin
        C    <= s2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_timer.sv
// Interval timer (TS/TL), car-sensor conditioning and
// emergency latch feeding the light-sequencing FSM.
module traffic_timer
  import traffic_pkg::*;
#(
  parameter int SHORT_CYCLES = SHORT_DEF,
  parameter int LONG_CYCLES  = LONG_DEF,
  parameter int CW           = 8,
  parameter int DEB_CYCLES   = DEB_DEF
) (
  input  logic Clk,
  input  logic reset,
  input  logic car_raw,
  input  logic emerg_req,
  traffic_timer_if.slave lf
);

  localparam logic [CW-1:0] SHORT_C = CW'(SHORT_CYCLES);
  localparam logic [CW-1:0] LONG_C  = CW'(LONG_CYCLES);

  logic [CW-1:0] cnt;
  logic e1;
  logic e2;
  logic c_w;
  emerg_state_t state_q;
  emerg_state_t state_d;

  // Saturating so TS/TL stay asserted however long the FSM waits.
  always_ff @(posedge Clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (lf.ST) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign lf.TS = (cnt >= SHORT_C);
  assign lf.TL = (cnt >= LONG_C);

  car_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_car (
    .Clk    (Clk),
    .reset  (reset),
    .car_raw(car_raw),
    .C      (c_w)
  );

  assign lf.C = c_w;

  always_ff @(posedge Clk) begin
    if (reset) begin
      e1      <= 1'b0;
      e2      <= 1'b0;
      state_q <= IDLE;
    end else begin
      e1      <= emerg_req;
      e2      <= e1;
      state_q <= state_d;
    end
  end

  // A request still pending at acknowledge keeps the latch set.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (e2) state_d = ARMED;
      ARMED:   if (lf.HY && !e2) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign lf.Emergency = (state_q == ARMED);

endmodule

// File: tb/tb_traffic_timer.sv
// Directed bench for traffic_timer: interval timing, saturation,
// debounce, emergency latch and reset recovery.
module tb_traffic_timer;

  logic Clk = 1'b0;
  logic reset;
  logic car_raw;
  logic emerg_req;
  int checks = 0;
  int errors = 0;

  traffic_timer_if bus ();

  traffic_timer dut (
    .Clk      (Clk),
    .reset    (reset),
    .car_raw  (car_raw),
    .emerg_req(emerg_req),
    .lf       (bus)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    car_raw   = 1'b0;
    emerg_req = 1'b0;
    bus.ST    = 1'b0;
    bus.HY    = 1'b0;
    tick();
    tick();
    chk("rst_TS", bus.TS, 1'b0);
    chk("rst_TL", bus.TL, 1'b0);
    chk("rst_C", bus.C, 1'b0);
    chk("rst_E", bus.Emergency, 1'b0);
    reset = 1'b0;

    // ST pulse, then walk up to TS and TL
    bus.ST = 1'b1;
    tick();
    bus.ST = 1'b0;
    chk("st_TS0", bus.TS, 1'b0);
    for (int n = 1; n < 5; n++) begin
      tick();
      chk("pre_TS", bus.TS, 1'b0);
    end
    tick();
    chk("TS_rise", bus.TS, 1'b1);
    chk("TL_lo5", bus.TL, 1'b0);
    repeat (14) tick();
    chk("TL_lo19", bus.TL, 1'b0);
    tick();
    chk("TL_rise", bus.TL, 1'b1);

    // saturation, then ST while both high
    repeat (300) tick();
    chk("sat_TS", bus.TS, 1'b1);
    chk("sat_TL", bus.TL, 1'b1);
    bus.ST = 1'b1;
    tick();
    bus.ST = 1'b0;
    chk("rest_TS", bus.TS, 1'b0);
    chk("rest_TL", bus.TL, 1'b0);
    repeat (4) tick();
    chk("rest_TS4", bus.TS, 1'b0);
    tick();
    chk("rest_TS5", bus.TS, 1'b1);

    // ST held four cycles: count from last high sample
    bus.ST = 1'b1;
    repeat (4) tick();
    bus.ST = 1'b0;
    chk("hold_TS0", bus.TS, 1'b0);
    repeat (4) tick();
    chk("hold_TS4", bus.TS, 1'b0);
    tick();
    chk("hold_TS5", bus.TS, 1'b1);

    // car rising edge
    car_raw = 1'b1;
    repeat (4) tick();
    chk("car_lo", bus.C, 1'b0);
    tick();
    chk("car_hi", bus.C, 1'b1);

    // 2-cycle low glitch while C=1
    car_raw = 1'b0;
    repeat (2) tick();
    car_raw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("glitch_hi", bus.C, 1'b1);
    end

    // car falling edge
    car_raw = 1'b0;
    repeat (4) tick();
    chk("car_fall_hold", bus.C, 1'b1);
    tick();
    chk("car_fall", bus.C, 1'b0);

    // 2-cycle high glitch while C=0
    car_raw = 1'b1;
    repeat (2) tick();
    car_raw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("glitch_lo", bus.C, 1'b0);
    end

    // one-cycle emergency request
    emerg_req = 1'b1;
    tick();
    emerg_req = 1'b0;
    chk("em_k", bus.Emergency, 1'b0);
    tick();
    chk("em_k1", bus.Emergency, 1'b0);
    tick();
    chk("em_k2", bus.Emergency, 1'b1);
    repeat (50) tick();
    chk("em_hold", bus.Emergency, 1'b1);
    bus.HY = 1'b1;
    tick();
    bus.HY = 1'b0;
    chk("em_ack", bus.Emergency, 1'b0);

    // acknowledge with request still active: set wins
    emerg_req = 1'b1;
    repeat (3) tick();
    chk("em_set2", bus.Emergency, 1'b1);
    bus.HY = 1'b1;
    tick();
    tick();
    bus.HY = 1'b0;
    chk("em_setwins", bus.Emergency, 1'b1);

    // reset mid-interval with C and Emergency set
    car_raw = 1'b1;
    bus.ST  = 1'b1;
    tick();
    bus.ST = 1'b0;
    repeat (12) tick();
    chk("pre_TS", bus.TS, 1'b1);
    chk("pre_TL", bus.TL, 1'b0);
    chk("pre_C", bus.C, 1'b1);
    chk("pre_E", bus.Emergency, 1'b1);
    reset     = 1'b1;
    car_raw   = 1'b0;
    emerg_req = 1'b0;
    tick();
    chk("mr_TS", bus.TS, 1'b0);
    chk("mr_TL", bus.TL, 1'b0);
    chk("mr_C", bus.C, 1'b0);
    chk("mr_E", bus.Emergency, 1'b0);
    reset = 1'b0;
    repeat (4) tick();
    chk("post_TS4", bus.TS, 1'b0);
    tick();
    chk("post_TS5", bus.TS, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
